// File: rtl/scroll_pkg.sv
// Shared types for the scroll speed/pause controller.
package scroll_pkg;
  localparam int LEVEL_W   = 3;
  localparam int MAX_LEVEL = 7;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef struct packed {
    logic pause;
    logic slower;
    logic faster;
  } btn_evt_t;
endpackage

// File: rtl/scroll_rate_ctrl_btn_debounce.sv
// One push-button front end: 2-flop synchronizer, counting debouncer and
// a registered one-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    db_d    = db_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // The sample that would make the run reach DB_CYCLES flips the value instead.
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        db_d    = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign btn_level = db_q;
  assign btn_press = press_q;
endmodule

// File: rtl/scroll_rate_ctrl.sv
// Speed/pause controller: debounced buttons select one of eight step rates
// and toggle pause; emits a registered one-cycle step enable.
module scroll_rate_ctrl
  import scroll_pkg::*;
#(
  parameter int BASE_PERIOD = 390625,
  parameter int DB_CYCLES   = 500000,
  parameter int RESET_LEVEL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_faster,
  input  logic               btn_slower,
  input  logic               btn_pause,
  output logic               step,
  output logic [LEVEL_W-1:0] level,
  output logic               paused
);
  localparam int DIV_W = $clog2(BASE_PERIOD * 128);

  logic [2:0] btn_raw;
  logic [2:0] btn_level_unused;
  btn_evt_t   evt;

  assign btn_raw = {btn_pause, btn_slower, btn_faster};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level_unused[i]),
      .btn_press (evt[i])
    );
  end

  level_t           level_q, level_d;
  logic             paused_q, paused_d;
  logic             step_q, step_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] last_cnt;

  // At level 0 with a power-of-two period the shift wraps to 0, and the
  // subtraction still lands on P-1 in DIV_W bits.
  assign last_cnt = (DIV_W'(BASE_PERIOD) << (LEVEL_W'(MAX_LEVEL) - level_q)) - 1'b1;

  always_comb begin
    level_d   = level_q;
    paused_d  = paused_q ^ evt.pause;
    div_cnt_d = div_cnt_q;
    step_d    = 1'b0;
    if (evt.faster && !evt.slower && level_q != LEVEL_W'(MAX_LEVEL))
      level_d = level_q + 1'b1;
    else if (evt.slower && !evt.faster && level_q != '0)
      level_d = level_q - 1'b1;

    if (level_d != level_q) begin
      div_cnt_d = '0;
    end else if (!paused_q) begin
      if (div_cnt_q == last_cnt) begin
        div_cnt_d = '0;
        step_d    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q   <= LEVEL_W'(RESET_LEVEL);
      paused_q  <= 1'b0;
      step_q    <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      level_q   <= level_d;
      paused_q  <= paused_d;
      step_q    <= step_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign step   = step_q;
  assign level  = level_q;
  assign paused = paused_q;
endmodule

// File: tb/tb_scroll_rate_ctrl.sv
// Bench for scroll_rate_ctrl: cycle scoreboard against a behavioural model
// plus directed timing checks per scenario.
module tb_scroll_rate_ctrl;
  localparam int BASE = 2;
  localparam int DB   = 4;
  localparam int RL   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_faster = 1'b0, btn_slower = 1'b0, btn_pause = 1'b0;
  logic       step, paused;
  logic [2:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scroll_rate_ctrl #(.BASE_PERIOD(BASE), .DB_CYCLES(DB), .RESET_LEVEL(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_faster (btn_faster),
    .btn_slower (btn_slower),
    .btn_pause  (btn_pause),
    .step       (step),
    .level      (level),
    .paused     (paused)
  );

  // Behavioural reference model; expected {level,paused,step} queued per edge.
  logic [2:0] m_raw;
  assign m_raw = {btn_pause, btn_slower, btn_faster};
  int   ms1[3], ms2[3], mdb[3], mcnt[3], mpr[3];
  int   m_level, m_div, m_nl, m_p;
  bit   m_paused, m_step;
  logic [4:0] sbq[$];
  logic [4:0] sb_e;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 3; b++) begin
        ms1[b] = 0; ms2[b] = 0; mdb[b] = 0; mcnt[b] = 0; mpr[b] = 0;
      end
      m_level = RL; m_div = 0; m_paused = 0; m_step = 0;
      sbq.delete();
      sbq.push_back({3'(RL), 1'b0, 1'b0});
    end else begin
      m_p  = BASE << (7 - m_level);
      m_nl = m_level;
      if (mpr[0] != 0 && mpr[1] == 0) m_nl = (m_level == 7) ? 7 : m_level + 1;
      if (mpr[1] != 0 && mpr[0] == 0) m_nl = (m_level == 0) ? 0 : m_level - 1;
      if (m_nl != m_level) begin m_div = 0; m_step = 0; end
      else if (m_paused) m_step = 0;
      else if (m_div == m_p - 1) begin m_div = 0; m_step = 1; end
      else begin m_div++; m_step = 0; end
      if (mpr[2] != 0) m_paused = !m_paused;
      m_level = m_nl;
      for (int b = 0; b < 3; b++) begin
        mpr[b] = 0;
        if (ms2[b] != mdb[b]) begin
          mcnt[b]++;
          if (mcnt[b] == DB) begin mdb[b] = ms2[b]; mcnt[b] = 0; mpr[b] = mdb[b]; end
        end else mcnt[b] = 0;
        ms2[b] = ms1[b];
        ms1[b] = int'(m_raw[b]);
      end
      sbq.push_back({3'(m_level), m_paused, m_step});
    end
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      sb_e = sbq.pop_front();
      n_cmp++;
      if ({level, paused, step} !== sb_e) begin
        n_bad++;
        $display("FAIL sb t=%0t got lvl=%0d p=%0b s=%0b want lvl=%0d p=%0b s=%0b",
                 $time, level, paused, step, sb_e[4:2], sb_e[1], sb_e[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int t;
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({level, paused, step} !== {3'd3, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset_vals got %0d/%0b/%0b want 3/0/0", level, paused, step);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      t = -1;
      for (int n = 1; n <= 40; n++) begin tick(); if (step) begin t = n; break; end end
      n_cmp++;
      if (t != 32) begin n_bad++; $display("FAIL first_step[%0d] got %0d edges want 32", k, t); end
    end
  endtask

  task automatic test_faster();
    int first, t;
    first = -1;
    btn_faster = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 10) btn_faster = 1'b0;
      if (n == 6) begin
        n_cmp++;
        if (level !== 3'd3) begin n_bad++; $display("FAIL faster_early got %0d want 3", level); end
      end
      if (n == 7) begin
        n_cmp++;
        if (level !== 3'd4) begin n_bad++; $display("FAIL faster_latency got %0d want 4", level); end
      end
      if (n > 7 && step && first < 0) first = n;
    end
    n_cmp++;
    if (first != 23) begin n_bad++; $display("FAIL faster_clear got step at %0d want 23", first); end
    for (int k = 0; k < 7; k++) begin
      btn_faster = 1'b1; repeat (8) tick();
      btn_faster = 1'b0; repeat (8) tick();
    end
    n_cmp++;
    if (level !== 3'd7) begin n_bad++; $display("FAIL faster_sat got %0d want 7", level); end
    for (int n = 1; n <= 10; n++) begin tick(); if (step) break; end
    t = -1;
    for (int n = 1; n <= 10; n++) begin tick(); if (step) begin t = n; break; end end
    n_cmp++;
    if (t != 2) begin n_bad++; $display("FAIL period_l7 got %0d want 2", t); end
  endtask

  task automatic test_slower();
    int t0, ts;
    for (int k = 0; k < 6; k++) begin
      btn_slower = 1'b1; repeat (8) tick();
      btn_slower = 1'b0; repeat (8) tick();
    end
    n_cmp++;
    if (level !== 3'd1) begin n_bad++; $display("FAIL slower_l1 got %0d want 1", level); end
    t0 = -1; ts = -1;
    for (int n = 1; n <= 500; n++) begin
      btn_slower = (n <= 80) && (((n - 1) % 16) < 8);
      tick();
      if (t0 < 0 && level == 3'd0) t0 = n;
      if (t0 >= 0 && ts < 0 && step) ts = n;
      if (ts >= 0 && n > 100) break;
    end
    btn_slower = 1'b0;
    n_cmp++;
    if (t0 != 7) begin n_bad++; $display("FAIL slower_to0 got edge %0d want 7", t0); end
    n_cmp++;
    if (ts - t0 != 256) begin n_bad++; $display("FAIL slower_noclear got %0d want 256", ts - t0); end
    n_cmp++;
    if (level !== 3'd0) begin n_bad++; $display("FAIL slower_sat got %0d want 0", level); end
  endtask

  task automatic test_both();
    int t;
    for (int k = 0; k < 3; k++) begin
      btn_faster = 1'b1; repeat (8) tick();
      btn_faster = 1'b0; repeat (8) tick();
    end
    n_cmp++;
    if (level !== 3'd3) begin n_bad++; $display("FAIL both_setup got %0d want 3", level); end
    for (int n = 1; n <= 40; n++) begin tick(); if (step) break; end
    btn_faster = 1'b1; btn_slower = 1'b1;
    t = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 8) begin btn_faster = 1'b0; btn_slower = 1'b0; end
      if (step) begin t = n; break; end
    end
    btn_faster = 1'b0; btn_slower = 1'b0;
    n_cmp++;
    if (t != 32) begin n_bad++; $display("FAIL both_noclear got %0d want 32", t); end
    n_cmp++;
    if (level !== 3'd3) begin n_bad++; $display("FAIL both_level got %0d want 3", level); end
  endtask

  task automatic test_pause();
    int t, bad_step;
    // Entered on the edge where div_cnt wrapped to 0; pause lands at div_cnt=10.
    repeat (3) tick();
    btn_pause = 1'b1;
    bad_step = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 8) btn_pause = 1'b0;
      if (n == 6) begin
        n_cmp++;
        if (paused !== 1'b0) begin n_bad++; $display("FAIL pause_early got %0b want 0", paused); end
      end
      if (n == 7) begin
        n_cmp++;
        if (paused !== 1'b1) begin n_bad++; $display("FAIL pause_on got %0b want 1", paused); end
      end
      if (n >= 7 && step) bad_step++;
    end
    n_cmp++;
    if (bad_step != 0) begin n_bad++; $display("FAIL pause_step got %0d steps want 0", bad_step); end
    btn_pause = 1'b1;
    t = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 8) btn_pause = 1'b0;
      if (n == 7) begin
        n_cmp++;
        if (paused !== 1'b0) begin n_bad++; $display("FAIL unpause got %0b want 0", paused); end
      end
      if (n > 7 && step && t < 0) t = n - 7;
    end
    n_cmp++;
    if (t != 22) begin n_bad++; $display("FAIL resume_step got %0d want 22", t); end
  endtask

  task automatic test_glitch();
    btn_pause = 1'b1; repeat (3) tick();
    btn_pause = 1'b0; repeat (20) tick();
    n_cmp++;
    if (paused !== 1'b0) begin n_bad++; $display("FAIL glitch got %0b want 0", paused); end
  endtask

  task automatic test_reset_mid();
    btn_faster = 1'b1; btn_pause = 1'b1; repeat (8) tick();
    btn_faster = 1'b0; btn_pause = 1'b0; repeat (8) tick();
    n_cmp++;
    if ({level, paused} !== {3'd4, 1'b1}) begin
      n_bad++; $display("FAIL rst_setup got %0d/%0b want 4/1", level, paused);
    end
    btn_faster = 1'b1; repeat (5) tick();
    reset = 1'b0;
    #2;
    n_cmp++;
    if ({level, paused, step} !== {3'd3, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL rst_async got %0d/%0b/%0b want 3/0/0", level, paused, step);
    end
    btn_faster = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if ({level, paused} !== {3'd3, 1'b0}) begin
      n_bad++; $display("FAIL rst_release got %0d/%0b want 3/0", level, paused);
    end
  endtask

  initial begin
    test_reset();
    test_faster();
    test_slower();
    test_both();
    test_pause();
    test_glitch();
    test_reset_mid();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scroll_rate_ctrl.md
# scroll_rate_ctrl

Speed and pause controller that sits directly upstream of the LED scroll pattern stage. It turns the board clock into a one-cycle `step` enable that advances the scroll pattern one position per pulse. The step rate is set by eight speed levels chosen with debounced faster/slower push-buttons, and a third button toggles pause. `level` and `paused` are exported for status LEDs or a 7-segment display.

## Interface
Parameters:
- `BASE_PERIOD`, 390625: step period in clk cycles at level 7 (128 Hz at 50 MHz).
- `DB_CYCLES`, 500000: consecutive identical samples needed to accept a button change (10 ms at 50 MHz).
- `RESET_LEVEL`, 3: speed level loaded at reset.

Ports:
- `clk`  in  1: board clock; the single clock domain.
- `reset`  in  1: asynchronous, active-low reset.
- `btn_faster`  in  1: raw pad input, active-high, asynchronous.
- `btn_slower`  in  1: raw pad input, active-high, asynchronous.
- `btn_pause`  in  1: raw pad input, active-high, asynchronous.
- `step`  out  1: one-cycle advance pulse for the scroll stage, used as its clock enable.
- `level`  out  3: current speed level, 0 is slowest and 7 is fastest.
- `paused`  out  1: high while stepping is suspended.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer:
  - The debouncer counts consecutive synchronized samples that differ from the stored debounced value.
  - When the count reaches `DB_CYCLES`, the debounced value flips and the counter clears.
  - Any sample equal to the debounced value clears the counter.
- A press event is a 0→1 transition of a debounced signal. Releases produce no event.
- Faster event: `level` increments, saturating at 7.
- Slower event: `level` decrements, saturating at 0.
- Faster and slower events in the same cycle: `level` unchanged.
- Pause event: `paused` toggles. It is independent of, and may coincide with, a level event.
- Step period: P = `BASE_PERIOD` << (7 − `level`). Level 0 gives 1 Hz and level 7 gives 128 Hz at defaults.
- Divider counter `div_cnt`:
  - Counts 0..P−1.
  - On the edge where `div_cnt` = P−1 it wraps to 0 and the registered `step` is set high for exactly one cycle.
- While `paused` = 1:
  - `div_cnt` holds its value and `step` = 0.
  - On un-pause, counting resumes from the held value.
- Any actual change of `level` clears `div_cnt` to 0 on the same edge. No `step` is issued on that edge, even if the count was at P−1. A saturated (no-op) level event does not clear the counter.
- Reset values: `level` = `RESET_LEVEL`, `paused` = 0, `step` = 0, `div_cnt` = 0, all synchronizer, debounce and edge registers = 0.
- Assertion of `reset` mid-operation (even mid-debounce or mid-period) forces all reset values immediately. No press event is generated at reset deassertion while a button is held low.
- Widths: `div_cnt` is $clog2(`BASE_PERIOD`·128) bits. The debounce counter is $clog2(`DB_CYCLES`+1) bits. No overflow is permitted at default or test parameters.

## Timing
- Press-to-effect latency: with a raw button rising and held stable, `level` or `paused` changes exactly `DB_CYCLES` + 3 rising edges after the first edge that samples the new value:
  - 2 edges for the synchronizer.
  - `DB_CYCLES` edges for the debouncer.
  - 1 edge for edge detect and apply.
- First `step` after reset release, unpaused: asserted after exactly P rising edges, then every P edges.
- `step` is registered and glitch-free. It is high for exactly one cycle per period.
- Glitches shorter than `DB_CYCLES` cycles produce no event.

## Structure
- Shared package `scroll_pkg`:
  - `LEVEL_W` = 3
  - `MAX_LEVEL` = 7
  - `level_t` typedef
- One sub-module, `btn_debounce`: synchronizer, debounce counter and rising-edge pulse, instantiated three times. Parameter `DB_CYCLES`; ports `clk`, `reset`, `btn_raw`, `btn_level`, `btn_press`.
- Top level holds the level/pause registers and the period divider.

## Test plan
Bench parameters: `BASE_PERIOD`=2, `DB_CYCLES`=4, `RESET_LEVEL`=3.
- Reset release, no buttons:
  - `level`=3 and `paused`=0.
  - First `step` 32 edges after release, then every 32 edges.
- Faster held 10 cycles:
  - `level`=4 exactly 7 edges after first sample.
  - `div_cnt` cleared; next `step` 16 edges later.
  - Seven more presses leave `level`=7, with P=2.
- Slower pressed 5 times from level 1: `level` reaches 0 and stays 0; `div_cnt` not cleared by the saturated presses.
- Faster and slower pressed on the same cycle: `level` unchanged, no counter clear.
- Pause pressed mid-period at `div_cnt`=10 at level 3:
  - `step` stays 0 and `div_cnt` holds 10.
  - Second pause press resumes; `step` fires 22 edges later.
- 3-cycle glitch on `btn_pause`: no toggle.
- `reset` asserted mid-debounce: all outputs return to reset values with no spurious event after release.
